// File: rtl/bp_cfg_boot_sequencer.sv
// Post-reset config loader: freezes each core, programs its id and CCE mode, then unfreezes
// all cores over the I/O command channel, with credit-bounded outstanding writes.
module bp_cfg_boot_sequencer #(
  parameter int num_core_p       = 2,
  parameter int cfg_addr_width_p = 20,
  parameter int cfg_data_width_p = 64,
  parameter int core_id_width_p  = 4,
  parameter int max_credits_p    = 4
) (
  input  logic                        clk_i,
  input  logic                        reset_n_i,
  input  logic                        start_i,
  output logic                        io_cmd_v_o,
  input  logic                        io_cmd_ready_i,
  output logic [core_id_width_p-1:0]  io_cmd_dst_o,
  output logic [cfg_addr_width_p-1:0] io_cmd_addr_o,
  output logic [cfg_data_width_p-1:0] io_cmd_data_o,
  input  logic                        io_resp_v_i,
  output logic                        io_resp_yumi_o,
  output logic                        busy_o,
  output logic                        done_o,
  output logic                        err_o
);

  localparam int cred_w_lp = $clog2(max_credits_p + 1);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CFG   = 3'd1;
  localparam logic [2:0] ST_UNFRZ = 3'd2;
  localparam logic [2:0] ST_DRAIN = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  localparam logic [cfg_addr_width_p-1:0] freeze_addr_lp  = cfg_addr_width_p'('h08);
  localparam logic [cfg_addr_width_p-1:0] core_id_addr_lp = cfg_addr_width_p'('h10);
  localparam logic [cfg_addr_width_p-1:0] cce_mode_addr_lp = cfg_addr_width_p'('h20);

  localparam logic [cred_w_lp-1:0]       max_cred_lp  = cred_w_lp'(max_credits_p);
  localparam logic [core_id_width_p-1:0] last_core_lp = core_id_width_p'(num_core_p - 1);

  logic [2:0]                 state_q, state_d;
  logic [core_id_width_p-1:0] core_q, core_d;
  logic [1:0]                 step_q, step_d;
  logic [cred_w_lp-1:0]       credits_q, credits_d;
  logic                       err_q, err_d;

  logic                        issue_ok;
  logic                        fire;
  logic                        last_core;
  logic [cfg_addr_width_p-1:0] cmd_addr;
  logic [cfg_data_width_p-1:0] cmd_data;

  // Issue and ack in the same cycle cancel; an ack never drives the count below zero.
  function automatic logic [cred_w_lp-1:0] credit_next(input logic [cred_w_lp-1:0] cur,
                                                       input logic inc,
                                                       input logic ack);
    logic [cred_w_lp-1:0] nxt;
    nxt = cur;
    if (inc && !ack)
      nxt = cur + cred_w_lp'(1);
    else if (!inc && ack && (cur != '0))
      nxt = cur - cred_w_lp'(1);
    return nxt;
  endfunction

  assign issue_ok  = ((state_q == ST_CFG) || (state_q == ST_UNFRZ)) && (credits_q < max_cred_lp);
  assign fire      = issue_ok && io_cmd_ready_i;
  assign last_core = (core_q == last_core_lp);

  always_comb begin
    cmd_addr = '0;
    cmd_data = '0;
    if (state_q == ST_CFG) begin
      case (step_q)
        2'd0: begin
          cmd_addr = freeze_addr_lp;
          cmd_data = cfg_data_width_p'(1);
        end
        2'd1: begin
          cmd_addr = core_id_addr_lp;
          cmd_data = cfg_data_width_p'(core_q);
        end
        default: begin
          cmd_addr = cce_mode_addr_lp;
          cmd_data = cfg_data_width_p'(1);
        end
      endcase
    end else if (state_q == ST_UNFRZ) begin
      cmd_addr = freeze_addr_lp;
      cmd_data = '0;
    end
  end

  always_comb begin
    state_d   = state_q;
    core_d    = core_q;
    step_d    = step_q;
    credits_d = credit_next(credits_q, fire, io_resp_v_i);
    err_d     = err_q | (io_resp_v_i && !fire && (credits_q == '0));
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_CFG;
          core_d  = '0;
          step_d  = '0;
        end
      end
      ST_CFG: begin
        if (fire) begin
          if (step_q == 2'd2) begin
            step_d = '0;
            if (last_core) begin
              core_d  = '0;
              state_d = ST_UNFRZ;
            end else begin
              core_d = core_q + core_id_width_p'(1);
            end
          end else begin
            step_d = step_q + 2'd1;
          end
        end
      end
      ST_UNFRZ: begin
        if (fire) begin
          if (last_core) begin
            core_d  = '0;
            state_d = ST_DRAIN;
          end else begin
            core_d = core_q + core_id_width_p'(1);
          end
        end
      end
      ST_DRAIN: begin
        if (credits_q == '0) state_d = ST_DONE;
      end
      ST_DONE: ;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q   <= ST_IDLE;
      core_q    <= '0;
      step_q    <= '0;
      credits_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      core_q    <= core_d;
      step_q    <= step_d;
      credits_q <= credits_d;
      err_q     <= err_d;
    end
  end

  // Command fields are forced to zero whenever no command is offered.
  assign io_cmd_v_o     = issue_ok;
  assign io_cmd_dst_o   = issue_ok ? core_q : '0;
  assign io_cmd_addr_o  = issue_ok ? cmd_addr : '0;
  assign io_cmd_data_o  = issue_ok ? cmd_data : '0;
  assign io_resp_yumi_o = io_resp_v_i;
  assign busy_o         = (state_q == ST_CFG) || (state_q == ST_UNFRZ) || (state_q == ST_DRAIN);
  assign done_o         = (state_q == ST_DONE);
  assign err_o          = err_q;

endmodule

// File: tb/tb_bp_cfg_boot_sequencer.sv
// Directed bench for bp_cfg_boot_sequencer with N=2 cores and four credits.
module tb_bp_cfg_boot_sequencer;

  logic        clk = 1'b0;
  logic        reset_n_i;
  logic        start_i;
  logic        io_cmd_v_o;
  logic        io_cmd_ready_i;
  logic [3:0]  io_cmd_dst_o;
  logic [19:0] io_cmd_addr_o;
  logic [63:0] io_cmd_data_o;
  logic        io_resp_v_i;
  logic        io_resp_yumi_o;
  logic        busy_o;
  logic        done_o;
  logic        err_o;

  always #5 clk = ~clk;

  bp_cfg_boot_sequencer #(
    .num_core_p(2), .cfg_addr_width_p(20), .cfg_data_width_p(64),
    .core_id_width_p(4), .max_credits_p(4)
  ) dut (
    .clk_i(clk), .reset_n_i(reset_n_i), .start_i(start_i),
    .io_cmd_v_o(io_cmd_v_o), .io_cmd_ready_i(io_cmd_ready_i),
    .io_cmd_dst_o(io_cmd_dst_o), .io_cmd_addr_o(io_cmd_addr_o), .io_cmd_data_o(io_cmd_data_o),
    .io_resp_v_i(io_resp_v_i), .io_resp_yumi_o(io_resp_yumi_o),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  int last_ack = -100;
  bit auto_ack = 1'b0;
  logic [3:0]  sr = '0;
  logic [87:0] wq [$];
  logic [87:0] exp_w [8];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Entered at posedge+1; returns at the next posedge+1 with inputs ready to drive.
  task automatic tick();
    #2;
    if (io_cmd_v_o && io_cmd_ready_i) wq.push_back({io_cmd_dst_o, io_cmd_addr_o, io_cmd_data_o});
    if (io_resp_v_i) last_ack = cyc;
    sr = {sr[2:0], io_cmd_v_o && io_cmd_ready_i};
    @(posedge clk);
    cyc++;
    #1;
    if (auto_ack) io_resp_v_i = sr[1];
  endtask

  task automatic do_reset();
    reset_n_i = 1'b0;
    start_i = 1'b0;
    io_cmd_ready_i = 1'b0;
    io_resp_v_i = 1'b0;
    auto_ack = 1'b0;
    sr = '0;
    tick();
    tick();
    reset_n_i = 1'b1;
    tick();
    wq.delete();
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  task automatic run_to_done(input int budget);
    int k;
    k = 0;
    while (!done_o && k < budget) begin
      tick();
      k++;
    end
    chk("done_reached", {63'd0, done_o}, 64'd1);
  endtask

  task automatic check_order(input string tag, input int n);
    chk({tag, "_count"}, 64'(wq.size()), 64'(n));
    for (int i = 0; i < n && i < wq.size(); i++) begin
      chk($sformatf("%s_w%0d_dst_addr", tag, i), 64'(wq[i][87:64]), 64'(exp_w[i][87:64]));
      chk($sformatf("%s_w%0d_data", tag, i), wq[i][63:0], exp_w[i][63:0]);
    end
  endtask

  initial begin
    exp_w[0] = {4'd0, 20'h00008, 64'd1};
    exp_w[1] = {4'd0, 20'h00010, 64'd0};
    exp_w[2] = {4'd0, 20'h00020, 64'd1};
    exp_w[3] = {4'd1, 20'h00008, 64'd1};
    exp_w[4] = {4'd1, 20'h00010, 64'd1};
    exp_w[5] = {4'd1, 20'h00020, 64'd1};
    exp_w[6] = {4'd0, 20'h00008, 64'd0};
    exp_w[7] = {4'd1, 20'h00008, 64'd0};

    reset_n_i = 1'b0;
    start_i = 1'b0;
    io_cmd_ready_i = 1'b0;
    io_resp_v_i = 1'b0;
    @(posedge clk);
    #1;
    do_reset();
    chk("rst_v", {63'd0, io_cmd_v_o}, 64'd0);
    chk("rst_dst_addr", {40'd0, io_cmd_dst_o, io_cmd_addr_o}, 64'd0);
    chk("rst_data", io_cmd_data_o, 64'd0);
    chk("rst_busy_done_err", {61'd0, busy_o, done_o, err_o}, 64'd0);

    // Full sequence: ready always high, acks two cycles after each issue.
    io_cmd_ready_i = 1'b1;
    auto_ack = 1'b1;
    pulse_start();
    chk("first_v", {63'd0, io_cmd_v_o}, 64'd1);
    chk("first_busy", {63'd0, busy_o}, 64'd1);
    run_to_done(100);
    chk("done_latency", 64'((cyc - 1) - last_ack), 64'd1);
    chk("seq_err", {63'd0, err_o}, 64'd0);
    check_order("seq", 8);
    repeat (3) tick();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    repeat (3) tick();
    chk("done_sticky", {62'd0, done_o, busy_o}, 64'd2);
    chk("done_v", {63'd0, io_cmd_v_o}, 64'd0);
    chk("done_no_restart", 64'(wq.size()), 64'd8);

    // Credit limit with acks withheld.
    do_reset();
    io_cmd_ready_i = 1'b1;
    pulse_start();
    repeat (10) tick();
    chk("cred_stall_count", 64'(wq.size()), 64'd4);
    chk("cred_stall_v_busy", {62'd0, io_cmd_v_o, busy_o}, 64'd1);
    io_resp_v_i = 1'b1;
    tick();
    io_resp_v_i = 1'b0;
    chk("cred_after_ack_count", 64'(wq.size()), 64'd4);
    chk("cred_after_ack_v", {63'd0, io_cmd_v_o}, 64'd1);
    tick();
    chk("cred_one_more", 64'(wq.size()), 64'd5);
    repeat (3) tick();
    chk("cred_refull_count", 64'(wq.size()), 64'd5);
    chk("cred_refull_v", {63'd0, io_cmd_v_o}, 64'd0);
    io_resp_v_i = 1'b1;
    tick();
    tick();
    io_resp_v_i = 1'b0;
    chk("cred_same_cycle_count", 64'(wq.size()), 64'd6);
    chk("cred_same_cycle_v", {63'd0, io_cmd_v_o}, 64'd1);
    tick();
    chk("cred_final_count", 64'(wq.size()), 64'd7);
    chk("cred_final_v", {63'd0, io_cmd_v_o}, 64'd0);
    chk("cred_err", {63'd0, err_o}, 64'd0);
    check_order("cred", 7);

    // Stray ack with nothing outstanding.
    do_reset();
    io_resp_v_i = 1'b1;
    #1;
    chk("yumi_follows_v", {63'd0, io_resp_yumi_o}, 64'd1);
    tick();
    io_resp_v_i = 1'b0;
    chk("stray_err", {63'd0, err_o}, 64'd1);
    repeat (3) tick();
    chk("stray_err_sticky", {61'd0, err_o, busy_o, done_o}, 64'd4);

    // Asynchronous reset in the middle of the configuration writes.
    do_reset();
    io_cmd_ready_i = 1'b1;
    auto_ack = 1'b1;
    pulse_start();
    for (int k = 0; k < 20 && wq.size() < 2; k++) tick();
    chk("mid_count", 64'(wq.size()), 64'd2);
    #2;
    reset_n_i = 1'b0;
    #1;
    chk("async_rst_v_busy", {62'd0, io_cmd_v_o, busy_o}, 64'd0);
    chk("async_rst_dst_addr", {40'd0, io_cmd_dst_o, io_cmd_addr_o}, 64'd0);
    chk("async_rst_data", io_cmd_data_o, 64'd0);
    @(posedge clk);
    #1;
    sr = '0;
    io_resp_v_i = 1'b0;
    reset_n_i = 1'b1;
    tick();
    wq.delete();

    // Restart, stall write 3 for five cycles, pulse start during the stall.
    pulse_start();
    for (int k = 0; k < 20 && wq.size() < 2; k++) tick();
    io_cmd_ready_i = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("stall%0d_v", k), {63'd0, io_cmd_v_o}, 64'd1);
      chk($sformatf("stall%0d_dst_addr", k), {40'd0, io_cmd_dst_o, io_cmd_addr_o},
          64'(exp_w[2][87:64]));
      chk($sformatf("stall%0d_data", k), io_cmd_data_o, exp_w[2][63:0]);
      start_i = (k == 1);
      tick();
    end
    start_i = 1'b0;
    chk("stall_count", 64'(wq.size()), 64'd2);
    io_cmd_ready_i = 1'b1;
    run_to_done(100);
    check_order("restart", 8);
    chk("restart_err", {63'd0, err_o}, 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
